// File: rtl/input_datapath_vc.sv
// input_datapath_vc: demuxes input flits into per-VC FIFOs and arbitrates non-empty VCs to the output.
module input_datapath_vc #(
    parameter int FLIT_WIDTH = 34,
    parameter int NUM_VC     = 3,
    parameter int VC_WIDTH   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int VC_DEPTH   = 4,
    parameter int ARB_MODE   = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  fin_valid_i,
    input  logic [VC_WIDTH-1:0]   fin_vc_i,
    input  logic [FLIT_WIDTH-1:0] fin_flit_i,
    output logic                  fin_ready_o,
    output logic                  fout_valid_o,
    output logic [VC_WIDTH-1:0]   fout_vc_o,
    output logic [FLIT_WIDTH-1:0] fout_flit_o,
    input  logic                  fout_ready_i,
    output logic [NUM_VC-1:0]     vc_full_o,
    output logic [NUM_VC-1:0]     vc_empty_o,
    output logic                  illegal_vc_o
);
    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam int CNT_W = $clog2(VC_DEPTH + 1);

    logic [FLIT_WIDTH-1:0] mem_q [NUM_VC][VC_DEPTH];
    logic [FLIT_WIDTH-1:0] mem_d [NUM_VC][VC_DEPTH];
    logic [PTR_W-1:0]      rptr_q [NUM_VC];
    logic [PTR_W-1:0]      rptr_d [NUM_VC];
    logic [PTR_W-1:0]      wptr_q [NUM_VC];
    logic [PTR_W-1:0]      wptr_d [NUM_VC];
    logic [CNT_W-1:0]      cnt_q [NUM_VC];
    logic [CNT_W-1:0]      cnt_d [NUM_VC];
    logic [VC_WIDTH-1:0]   rr_q, rr_d, hold_vc_q, hold_vc_d, cand, sel;
    logic                  hold_q, hold_d, illegal_q, illegal_d;
    logic                  in_legal, push, pop, any_ne, fout_valid;
    int                    idx;

    assign in_legal     = 32'(fin_vc_i) < NUM_VC;
    assign fin_ready_o  = in_legal ? ~vc_full_o[fin_vc_i] : 1'b1;
    assign push         = fin_valid_i & fin_ready_o & in_legal;
    assign sel          = hold_q ? hold_vc_q : cand;
    assign fout_valid   = hold_q | any_ne;
    assign pop          = fout_valid & fout_ready_i;
    assign fout_valid_o = fout_valid;
    assign fout_vc_o    = fout_valid ? sel : '0;
    assign fout_flit_o  = fout_valid ? mem_q[sel][rptr_q[sel]] : '0;
    assign illegal_vc_o = illegal_q;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_full_o[v]  = cnt_q[v] == CNT_W'(VC_DEPTH);
            vc_empty_o[v] = cnt_q[v] == '0;
        end
    end

    // Scan VCs in priority order; the first non-empty one is the candidate.
    always_comb begin
        cand   = '0;
        any_ne = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = ARB_MODE == 2 ? (int'(rr_q) + i) % NUM_VC : ARB_MODE == 0 ? i : NUM_VC - 1 - i;
            if (!any_ne && !vc_empty_o[idx]) begin
                cand   = VC_WIDTH'(idx);
                any_ne = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d  = mem_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        for (int v = 0; v < NUM_VC; v++) begin
            if (push && fin_vc_i == VC_WIDTH'(v)) begin
                mem_d[v][wptr_q[v]] = fin_flit_i;
                wptr_d[v]           = wptr_q[v] + PTR_W'(1);
            end
            if (pop && sel == VC_WIDTH'(v))
                rptr_d[v] = rptr_q[v] + PTR_W'(1);
            cnt_d[v] = cnt_q[v] + CNT_W'(push && fin_vc_i == VC_WIDTH'(v)) - CNT_W'(pop && sel == VC_WIDTH'(v));
        end
        rr_d      = (ARB_MODE == 2 && pop) ? (int'(sel) == NUM_VC - 1 ? '0 : sel + VC_WIDTH'(1)) : rr_q;
        hold_d    = fout_valid & ~fout_ready_i;
        hold_vc_d = hold_d ? sel : '0;
        illegal_d = fin_valid_i & ~in_legal;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            mem_q     <= '{default: '0};
            rptr_q    <= '{default: '0};
            wptr_q    <= '{default: '0};
            cnt_q     <= '{default: '0};
            rr_q      <= '0;
            hold_q    <= 1'b0;
            hold_vc_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            hold_vc_q <= hold_vc_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_input_datapath_vc.sv
// tb_input_datapath_vc: three instances (one per arbitration mode) share stimulus; a monitor
// compares every cycle against per-VC expected queues and the arbitration rules.
module tb_input_datapath_vc;
    localparam int FW = 34;
    localparam int NV = 3;
    localparam int VW = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          fin_valid_i;
    logic [VW-1:0] fin_vc_i;
    logic [FW-1:0] fin_flit_i;
    logic          fout_ready_i;
    logic          fin_ready [3];
    logic          fout_valid [3];
    logic [VW-1:0] fout_vc [3];
    logic [FW-1:0] fout_flit [3];
    logic [NV-1:0] vc_full [3];
    logic [NV-1:0] vc_empty [3];
    logic          illegal [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        input_datapath_vc #(.FLIT_WIDTH(FW), .NUM_VC(NV), .VC_DEPTH(D), .ARB_MODE(g)) u_dut (
            .clk(clk), .arst(arst),
            .fin_valid_i(fin_valid_i), .fin_vc_i(fin_vc_i), .fin_flit_i(fin_flit_i),
            .fin_ready_o(fin_ready[g]),
            .fout_valid_o(fout_valid[g]), .fout_vc_o(fout_vc[g]), .fout_flit_o(fout_flit[g]),
            .fout_ready_i(fout_ready_i),
            .vc_full_o(vc_full[g]), .vc_empty_o(vc_empty[g]), .illegal_vc_o(illegal[g])
        );
    end

    logic [FW-1:0] mq [3][NV][$];
    int            rr [3];
    int            held [3];
    bit            ill_flag [3];
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(string name, int m, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s mode%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
        end
    endtask

    // Instance m runs arbitration mode m; a held VC always wins.
    function automatic int pick(int m);
        if (held[m] >= 0) return held[m];
        for (int i = 0; i < NV; i++) begin
            int v = m == 0 ? i : m == 1 ? NV - 1 - i : (rr[m] + i) % NV;
            if (mq[m][v].size() > 0) return v;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!arst)
            for (int m = 0; m < 3; m++) begin
                for (int v = 0; v < NV; v++) mq[m][v].delete();
                rr[m] = 0;
                held[m] = -1;
                ill_flag[m] = 1'b0;
            end
        for (int m = 0; m < 3; m++) begin
            int e;
            logic [FW-1:0] ex;
            logic [NV-1:0] ef, ee;
            bit rdy_exp;
            e = pick(m);
            ex = '0;
            if (e >= 0) ex = mq[m][e][0];
            for (int v = 0; v < NV; v++) begin
                ef[v] = mq[m][v].size() == D;
                ee[v] = mq[m][v].size() == 0;
            end
            rdy_exp = 1'b1;
            if (fin_vc_i < NV) rdy_exp = mq[m][fin_vc_i].size() < D;
            chk("valid", m, 64'(fout_valid[m]), 64'(e >= 0));
            chk("vc", m, 64'(fout_vc[m]), 64'(e >= 0 ? e : 0));
            chk("flit", m, 64'(fout_flit[m]), 64'(ex));
            chk("full", m, 64'(vc_full[m]), 64'(ef));
            chk("empty", m, 64'(vc_empty[m]), 64'(ee));
            chk("fin_ready", m, 64'(fin_ready[m]), 64'(rdy_exp));
            chk("illegal", m, 64'(illegal[m]), 64'(ill_flag[m]));
            ill_flag[m] = 1'b0;
            if (e >= 0 && fout_ready_i) begin
                void'(mq[m][e].pop_front());
                if (m == 2) rr[m] = (e + 1) % NV;
                held[m] = -1;
            end else begin
                held[m] = e;
            end
        end
    end

    task automatic cyc(bit v, int vc, logic [FW-1:0] f, bit rdy);
        @(posedge clk);
        #1;
        fin_valid_i  = v;
        fin_vc_i     = VW'(vc);
        fin_flit_i   = f;
        fout_ready_i = rdy;
        @(negedge clk);
        #1;
        for (int m = 0; m < 3; m++)
            if (fin_valid_i && fin_ready[m]) begin
                if (fin_vc_i < NV) mq[m][fin_vc_i].push_back(fin_flit_i);
                else ill_flag[m] = 1'b1;
            end
    endtask

    task automatic rand_run(int n);
        for (int i = 0; i < n; i++) begin
            bit hi = ((i / 150) % 2) == 0;
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0 ? 3 : int'($urandom_range(0, 2)),
                FW'({$urandom(), $urandom()}),
                hi ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        fin_valid_i  = 1'b0;
        fin_vc_i     = '0;
        fin_flit_i   = '0;
        fout_ready_i = 1'b0;
        repeat (3) cyc(0, 0, '0, 0);
        @(posedge clk);
        #2;
        arst = 1'b1;
        for (int k = 1; k <= 5; k++) cyc(1, 2, FW'(k), 0);
        cyc(0, 0, '0, 0);
        repeat (6) cyc(0, 0, '0, 1);
        cyc(1, 2, FW'(6), 1);
        cyc(1, 2, FW'(7), 1);
        repeat (3) cyc(0, 0, '0, 1);
        cyc(1, 0, FW'('h01), 0);
        cyc(1, 1, FW'('h11), 0);
        cyc(1, 2, FW'('h21), 0);
        repeat (4) cyc(0, 0, '0, 1);
        for (int k = 0; k < 6; k++) cyc(1, k % 3, FW'('h30 + k), 0);
        repeat (7) cyc(0, 0, '0, 1);
        cyc(1, 0, FW'('h40), 0);
        cyc(1, 2, FW'('h42), 0);
        cyc(0, 0, '0, 0);
        repeat (3) cyc(0, 0, '0, 1);
        cyc(1, 3, FW'('h55), 1);
        repeat (2) cyc(0, 0, '0, 1);
        cyc(1, 1, FW'('h61), 0);
        cyc(1, 1, FW'('h62), 0);
        cyc(1, 1, FW'('h63), 1);
        repeat (4) cyc(0, 0, '0, 1);
        rand_run(1500);
        cyc(1, 0, FW'('h71), 0);
        cyc(1, 1, FW'('h72), 0);
        @(posedge clk);
        #1;
        fin_valid_i  = 1'b0;
        fout_ready_i = 1'b0;
        #2;
        arst = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("rst_valid", m, 64'(fout_valid[m]), 64'd0);
            chk("rst_empty", m, 64'(vc_empty[m]), 64'h7);
            chk("rst_full", m, 64'(vc_full[m]), 64'd0);
            chk("rst_vc", m, 64'(fout_vc[m]), 64'd0);
            chk("rst_flit", m, 64'(fout_flit[m]), 64'd0);
            chk("rst_illegal", m, 64'(illegal[m]), 64'd0);
        end
        repeat (2) cyc(0, 0, '0, 0);
        @(posedge clk);
        #2;
        arst = 1'b1;
        cyc(1, 1, FW'('h81), 0);
        cyc(1, 0, FW'('h80), 1);
        cyc(1, 2, FW'('h82), 1);
        repeat (4) cyc(0, 0, '0, 1);
        rand_run(500);
        repeat (20) cyc(0, 0, '0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/input_datapath_vc.md
# input_datapath_vc

Parametrised router input datapath. It demultiplexes flits arriving on one router input port into `NUM_VC` per-virtual-channel FIFOs of depth `VC_DEPTH`, then arbitrates among non-empty VCs toward the router output side. The arbitration mode is selectable: fixed low-first, fixed high-first, or round-robin. The output is held stable under backpressure. The block sits between the upstream link and the router routing/crossbar stage, one instance per router input port, and replaces the fixed 3-VC input datapath.

## Interface

**Parameters**
- `FLIT_WIDTH`, default 34: flit payload width in bits; it excludes VC id and valid.
- `NUM_VC`, default 3: number of virtual channels; range ≥ 1.
- `VC_WIDTH`, derived: `$clog2(NUM_VC)`, forced to a minimum of 1.
- `VC_DEPTH`, default 4: entries per VC FIFO; a power of two and ≥ 2.
- `ARB_MODE`, default 1: arbitration mode.
  - 0: lowest VC index wins.
  - 1: highest VC index wins.
  - 2: round-robin.

**Ports**
- `clk`  in  1  clock; all state changes on the rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `fin_valid_i`  in  1  upstream flit valid.
- `fin_vc_i`  in  `VC_WIDTH`  target VC of the upstream flit.
- `fin_flit_i`  in  `FLIT_WIDTH`  upstream flit payload.
- `fin_ready_o`  out  1  upstream ready; a push occurs on `fin_valid_i & fin_ready_o`.
- `fout_valid_o`  out  1  selected VC has a flit.
- `fout_vc_o`  out  `VC_WIDTH`  VC id of the presented flit.
- `fout_flit_o`  out  `FLIT_WIDTH`  head entry of the selected VC.
- `fout_ready_i`  in  1  downstream ready; a pop occurs on `fout_valid_o & fout_ready_i`.
- `vc_full_o`  out  `NUM_VC`  per-VC full flag.
- `vc_empty_o`  out  `NUM_VC`  per-VC empty flag.
- `illegal_vc_o`  out  1  one-cycle pulse when a flit is pushed with `fin_vc_i >= NUM_VC`.

## Operation

**Reset values**
- Reset is asserted while `arst` = 0.
- On reset, all FIFOs are emptied, all pointers and counters are zeroed, the round-robin pointer is set to 0, and the hold state is cleared.
- Output values during reset:
  - `fout_valid_o` = 0.
  - `vc_empty_o` = all ones.
  - `vc_full_o` = 0.
  - `illegal_vc_o` = 0.
  - `fout_vc_o` = 0.
  - `fout_flit_o` = 0.

**Input side**
- `fin_ready_o` = `~vc_full_o[fin_vc_i]` for a legal VC, and 1 for an illegal VC.
- An illegal-VC flit is consumed and discarded; `illegal_vc_o` pulses on the following cycle.
- There is no full-FIFO bypass: a full VC deasserts ready even when the same VC is being popped that cycle.

**FIFOs**
- Each FIFO keeps a read pointer, a write pointer and an occupancy counter `0..VC_DEPTH`.
- Pointers are `$clog2(VC_DEPTH)` bits wide and wrap naturally.
- Full is occupancy == `VC_DEPTH`; empty is occupancy == 0.
- A push and a pop on the same VC in the same cycle leave occupancy unchanged.

**Arbitration (combinational selection of a candidate VC from the non-empty set)**
- Mode 0: lowest non-empty index.
- Mode 1: highest non-empty index.
- Mode 2: the first non-empty index at or above the round-robin pointer, wrapping modulo `NUM_VC`.
- After each pop on VC k in mode 2, the pointer becomes `(k+1) mod NUM_VC`.
- In modes 0 and 1 the pointer is unused.

**Hold (stability rule)**
- If `fout_valid_o` = 1 and `fout_ready_i` = 0, the block registers the presented VC as held.
- While held, the next cycle presents the same VC and flit regardless of new arrivals on other VCs.
- The hold is released on the handshake cycle.

**Output data**
- `fout_flit_o` and `fout_vc_o` are driven from the selected FIFO head.
- When `fout_valid_o` = 0, both are 0.

## Timing
- Input-to-output latency is 1 cycle: a flit pushed at edge N into an empty VC can be presented (`fout_valid_o` = 1) in the cycle after edge N, if it wins arbitration.
- Throughput is 1 flit per cycle in and 1 flit per cycle out, sustained.
- A flag update is visible the cycle after the push or pop edge.
- The round-robin pointer and hold register update on the same edge as the pop.
- If reset is asserted mid-transfer, all in-flight flits are lost, outputs take their reset values immediately (asynchronously), and no handshake completes on that edge.

## Test plan
- **Fill and drain:** `NUM_VC`=3, `VC_DEPTH`=4; push 4 flits 0x1..0x4 to VC2 with `fout_ready_i` = 0.
  - Required: `vc_full_o`=3'b100 after the 4th push, and `fin_ready_o`=0 for VC2.
  - Then raise ready. Required: flits pop in order 0x1..0x4, `vc_empty_o` returns to 3'b111, and the FIFO holds no stale data after pointer wrap.
- **Fixed priority:** `ARB_MODE`=1; VC0, VC1 and VC2 each hold one flit.
  - Required: output order VC2, VC1, VC0.
  - With `ARB_MODE`=0, the required order is VC0, VC1, VC2.
- **Round-robin:** `ARB_MODE`=2; all 3 VCs hold 2 flits each and ready is held at 1.
  - Required VC order: 0,1,2,0,1,2.
- **Hold under backpressure:** `ARB_MODE`=1; VC0 is presented with `fout_ready_i`=0, then a flit is pushed to VC2.
  - Required: the output stays VC0 with an unchanged flit until the handshake, and VC2 is presented on the next cycle.
- **Illegal VC and concurrency:** push with `fin_vc_i`=3.
  - Required: `fin_ready_o`=1, `illegal_vc_o` pulses for 1 cycle, and no occupancy changes.
  - Then push and pop VC1 simultaneously at occupancy 2. Required: occupancy stays 2.
- **Async reset:** drop `arst` with 2 flits buffered.
  - Required: `fout_valid_o`=0 and `vc_empty_o`=all ones immediately, and the round-robin pointer restarts at VC0.
